// File: rtl/lif_adder_scheduler_pkg.sv
// Shared definitions for the LIF adder scheduler: controller state encoding,
// default word width and the LIF firing threshold.
package lif_sched_pkg;

    // Controller states, 3-bit encoding
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_READ    = 3'd2,
        S_CAPTURE = 3'd3,
        S_SETTLE  = 3'd4,
        S_WRITE   = 3'd5,
        S_DONE    = 3'd6
    } sched_state_e;

    // IEEE-754 single-precision word width
    localparam int LIF_DATA_W = 32;

    // Firing threshold of the external potential adder (40.0)
    localparam logic [31:0] LIF_THRESHOLD = 32'h42200000;

endpackage

// File: rtl/lif_adder_scheduler_if.sv
// Neuron-memory and potential-adder bus of the LIF adder scheduler.
// master: scheduler side; slave: memory/adder side.
interface lif_adder_scheduler_if #(
    parameter int NUM_NEURONS = 4,
    parameter int DATA_W      = 32
);
    localparam int IDX_W = $clog2(NUM_NEURONS);

    // Neuron potential memory
    logic              mem_rd_en;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_rd_weight;
    logic [DATA_W-1:0] mem_rd_vdec;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wr_data;

    // Shared combinational potential adder
    logic              adder_set;
    logic              adder_clear;
    logic [DATA_W-1:0] adder_weight;
    logic [DATA_W-1:0] adder_vdec;
    logic [DATA_W-1:0] adder_final;
    logic              adder_spike;

    modport master (
        output mem_rd_en, mem_idx, mem_wr_en, mem_wr_data,
        output adder_set, adder_clear, adder_weight, adder_vdec,
        input  mem_rd_weight, mem_rd_vdec, adder_final, adder_spike
    );

    modport slave (
        input  mem_rd_en, mem_idx, mem_wr_en, mem_wr_data,
        input  adder_set, adder_clear, adder_weight, adder_vdec,
        output mem_rd_weight, mem_rd_vdec, adder_final, adder_spike
    );

endinterface

// File: rtl/lif_adder_scheduler.sv
// LIF adder scheduler: on each timestep walks every neuron through
// read -> capture operands -> settle -> write-back using one shared adder.
// Optional macro LIF_SCHED_SPIKE_COUNT_EN adds a per-timestep spike counter
// output (spike_count).
module lif_adder_scheduler
    import lif_sched_pkg::*;
#(
    parameter int NUM_NEURONS   = 4,
    parameter int DATA_W        = LIF_DATA_W,
    parameter int SETTLE_CYCLES = 1,
    localparam int IDX_W        = $clog2(NUM_NEURONS)
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   ts_start,
    input  logic                   ts_abort,
    output logic                   ts_busy,
    output logic                   ts_done,
    output logic [NUM_NEURONS-1:0] spike_vec,
`ifdef LIF_SCHED_SPIKE_COUNT_EN
    output logic [IDX_W:0]         spike_count,
`endif
    lif_adder_scheduler_if.master  bus
);

    // Counter only has to reach SETTLE_CYCLES
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_NEURONS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    sched_state_e              state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]         weight_q, weight_d;
    logic [DATA_W-1:0]         vdec_q, vdec_d;
    logic [NUM_NEURONS-1:0]    spike_vec_q, spike_vec_d;
`ifdef LIF_SCHED_SPIKE_COUNT_EN
    logic [IDX_W:0]            spike_cnt_q, spike_cnt_d;
`endif

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state and datapath next values; abort overrides every transition
    // and suppresses all side effects of the current state
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        weight_d    = weight_q;
        vdec_d      = vdec_q;
        spike_vec_d = spike_vec_q;
`ifdef LIF_SCHED_SPIKE_COUNT_EN
        spike_cnt_d = spike_cnt_q;
`endif
        if (ts_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ts_start) state_d = S_INIT;
                end
                S_INIT: begin
                    spike_vec_d = '0;
                    idx_d       = '0;
`ifdef LIF_SCHED_SPIKE_COUNT_EN
                    spike_cnt_d = '0;
`endif
                    state_d     = S_READ;
                end
                S_READ: begin
                    state_d = S_CAPTURE;
                end
                S_CAPTURE: begin
                    weight_d = bus.mem_rd_weight;
                    vdec_d   = bus.mem_rd_vdec;
                    cnt_d    = '0;
                    state_d  = S_SETTLE;
                end
                S_SETTLE: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == SETTLE_LAST) state_d = S_WRITE;
                end
                S_WRITE: begin
                    spike_vec_d[idx_q] = bus.adder_spike;
`ifdef LIF_SCHED_SPIKE_COUNT_EN
                    if (bus.adder_spike) spike_cnt_d = spike_cnt_q + (IDX_W+1)'(1);
`endif
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_READ;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Index, settle counter, operand and spike registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            idx_q       <= '0;
            cnt_q       <= '0;
            weight_q    <= '0;
            vdec_q      <= '0;
            spike_vec_q <= '0;
`ifdef LIF_SCHED_SPIKE_COUNT_EN
            spike_cnt_q <= '0;
`endif
        end else begin
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            weight_q    <= weight_d;
            vdec_q      <= vdec_d;
            spike_vec_q <= spike_vec_d;
`ifdef LIF_SCHED_SPIKE_COUNT_EN
            spike_cnt_q <= spike_cnt_d;
`endif
        end
    end

    // Moore outputs; write strobe and done pulse are masked by abort
    always_comb begin
        ts_busy          = (state_q != S_IDLE);
        ts_done          = (state_q == S_DONE) && !ts_abort;
        bus.mem_rd_en    = (state_q == S_READ);
        bus.mem_idx      = idx_q;
        bus.mem_wr_en    = (state_q == S_WRITE) && !ts_abort;
        bus.mem_wr_data  = '0;
        if (bus.mem_wr_en) bus.mem_wr_data = bus.adder_final;
        bus.adder_set    = (state_q == S_INIT);
        bus.adder_clear  = (state_q == S_IDLE);
        bus.adder_weight = weight_q;
        bus.adder_vdec   = vdec_q;
        spike_vec        = spike_vec_q;
`ifdef LIF_SCHED_SPIKE_COUNT_EN
        spike_count      = spike_cnt_q;
`endif
    end

endmodule

// File: tb/tb_lif_adder_scheduler.sv
// Self-checking bench for lif_adder_scheduler with a neuron memory model,
// an integer-valued stand-in for the external potential adder and a
// timestep-level reference model.
module tb_lif_adder_scheduler;
    import lif_sched_pkg::*;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int S   = 1;
    localparam int IW  = $clog2(N);
    localparam int THR = 40;                 // 0x42200000 == 40.0
    localparam int DONE_CYC = 2 + N * (3 + S);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ts_start;
    logic          ts_abort;
    logic          ts_busy;
    logic          ts_done;
    logic [N-1:0]  spike_vec;
`ifdef LIF_SCHED_SPIKE_COUNT_EN
    logic [IW:0]   spike_count;
`endif

    lif_adder_scheduler_if #(.NUM_NEURONS(N), .DATA_W(DW)) bus ();

    lif_adder_scheduler #(
        .NUM_NEURONS  (N),
        .DATA_W       (DW),
        .SETTLE_CYCLES(S)
    ) u_dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .ts_start   (ts_start),
        .ts_abort   (ts_abort),
        .ts_busy    (ts_busy),
        .ts_done    (ts_done),
        .spike_vec  (spike_vec),
`ifdef LIF_SCHED_SPIKE_COUNT_EN
        .spike_count(spike_count),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Exact conversion of small non-negative integers to/from single precision
    function automatic logic [31:0] int_to_f32(input int n);
        int e;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        e = 0;
        for (int b = 0; b < 31; b++) if (((n >> b) & 1) != 0) e = b;
        m = 32'(n) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic int f32_to_int(input logic [31:0] f);
        int e;
        logic [31:0] m;
        if (f[30:0] == 31'h0) return 0;
        e = int'(f[30:23]) - 127;
        m = {8'h0, 1'b1, f[22:0]};
        return int'(m >> (23 - e));
    endfunction

    // Stand-in for the external adder: spike when sum reaches threshold,
    // potential reset by subtraction
    function automatic logic [32:0] adder_stub(input logic [31:0] w, input logic [31:0] v);
        int s;
        int thr;
        thr = f32_to_int(LIF_THRESHOLD);
        s   = f32_to_int(w) + f32_to_int(v);
        if (s >= thr) return {1'b1, int_to_f32(s - thr)};
        return {1'b0, int_to_f32(s)};
    endfunction

    always_comb {bus.adder_spike, bus.adder_final} = adder_stub(bus.adder_weight, bus.adder_vdec);

    // Neuron memory: read data valid the cycle after the strobe
    int w_int [N];
    int v_int [N];
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_rd_weight <= int_to_f32(w_int[bus.mem_idx]);
            bus.mem_rd_vdec   <= int_to_f32(v_int[bus.mem_idx]);
        end
    end

    // Cycle bookkeeping and output monitor
    int          edges = 0;
    int          t0 = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          wr_idx_q [$];
    logic [31:0] wr_dat_q [$];
    logic        busy_hist [64];

    always @(posedge clk) edges <= edges + 1;

    always @(negedge clk) begin
        check_eq("set_clear_exclusive", 64'(bus.adder_set & bus.adder_clear), 64'h0);
        if (rst_n && bus.mem_wr_en) begin
            wr_idx_q.push_back(int'(bus.mem_idx));
            wr_dat_q.push_back(bus.mem_wr_data);
        end
        if (ts_done) begin
            done_cnt++;
            done_cyc = edges - t0;
        end
    end

    // Reference model results for the loaded neuron values
    function automatic logic [31:0] exp_final(input int i);
        int s;
        s = w_int[i] + v_int[i];
        return int_to_f32((s >= THR) ? s - THR : s);
    endfunction

    function automatic logic [N-1:0] exp_spikes();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = ((w_int[i] + v_int[i]) >= THR);
        return r;
    endfunction

    task automatic load_random();
        for (int i = 0; i < N; i++) begin
            w_int[i] = int'($urandom_range(0, 60));
            v_int[i] = int'($urandom_range(0, 60));
        end
    endtask

    // Run one timestep; cycle c is the one following edge c-1 after the start
    task automatic run_ts(input int restart_cyc, input int abort_cyc);
        wr_idx_q.delete();
        wr_dat_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        @(negedge clk);
        t0 = edges;
        ts_start = 1'b1;
        for (int c = 1; c < 41; c++) begin
            @(negedge clk);
            busy_hist[c] = ts_busy;
            ts_start = (c == restart_cyc);
            ts_abort = (c == abort_cyc);
        end
        ts_start = 1'b0;
        ts_abort = 1'b0;
    endtask

    task automatic check_full_ts(input string tag);
        logic [N-1:0] ev;
        ev = exp_spikes();
        check_eq({tag, "_n_writes"}, 64'(wr_idx_q.size()), 64'(N));
        for (int i = 0; i < N; i++) begin
            if (i < wr_idx_q.size()) begin
                check_eq({tag, "_wr_idx"}, 64'(wr_idx_q[i]), 64'(i));
                check_eq({tag, "_wr_data"}, 64'(wr_dat_q[i]), 64'(exp_final(i)));
            end
        end
        check_eq({tag, "_spike_vec"}, 64'(spike_vec), 64'(ev));
        check_eq({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check_eq({tag, "_done_cyc"}, 64'(done_cyc), 64'(DONE_CYC));
        check_eq({tag, "_busy_init"}, 64'(busy_hist[1]), 64'd1);
        check_eq({tag, "_busy_after"}, 64'(busy_hist[DONE_CYC + 1]), 64'd0);
`ifdef LIF_SCHED_SPIKE_COUNT_EN
        check_eq({tag, "_spike_count"}, 64'(spike_count), 64'($countones(ev)));
`endif
    endtask

    initial begin
        logic [N-1:0] ev;
        int waited;
        rst_n    = 1'b0;
        ts_start = 1'b0;
        ts_abort = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_int[i] = 0;
            v_int[i] = 0;
        end

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(ts_busy), 64'd0);
        check_eq("rst_done", 64'(ts_done), 64'd0);
        check_eq("rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
        check_eq("rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
        check_eq("rst_idx", 64'(bus.mem_idx), 64'd0);
        check_eq("rst_wr_data", 64'(bus.mem_wr_data), 64'd0);
        check_eq("rst_set", 64'(bus.adder_set), 64'd0);
        check_eq("rst_clear", 64'(bus.adder_clear), 64'd1);
        check_eq("rst_weight", 64'(bus.adder_weight), 64'd0);
        check_eq("rst_vdec", 64'(bus.adder_vdec), 64'd0);
        check_eq("rst_spike_vec", 64'(spike_vec), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("idle_busy", 64'(ts_busy), 64'd0);
            check_eq("idle_clear", 64'(bus.adder_clear), 64'd1);
        end

        // Directed spike / no-spike neurons plus random remainder
        load_random();
        w_int[0] = 10; v_int[0] = 35;
        w_int[1] = 10; v_int[1] = 20;
        run_ts(-1, -1);
        check_full_ts("directed");
        if (wr_dat_q.size() >= 2) begin
            check_eq("spike_path_data", 64'(wr_dat_q[0]), 64'h40A00000);
            check_eq("nospike_path_data", 64'(wr_dat_q[1]), 64'h41F00000);
        end else begin
            check_eq("directed_writes_present", 64'(wr_dat_q.size()), 64'd2);
        end
        check_eq("spike_path_bit", 64'(spike_vec[0]), 64'd1);
        check_eq("nospike_path_bit", 64'(spike_vec[1]), 64'd0);

        // Random timesteps
        for (int t = 0; t < 5; t++) begin
            load_random();
            run_ts(-1, -1);
            check_full_ts("random");
        end

        // Start pulse during SETTLE of neuron 2 is ignored
        load_random();
        run_ts(4 + 4 * 2, -1);
        check_full_ts("ignored_start");

        // Abort during READ of neuron 2
        load_random();
        ev = exp_spikes();
        run_ts(-1, 2 + 4 * 2);
        check_eq("abort_n_writes", 64'(wr_idx_q.size()), 64'd2);
        for (int i = 0; i < 2; i++) begin
            if (i < wr_idx_q.size()) begin
                check_eq("abort_wr_idx", 64'(wr_idx_q[i]), 64'(i));
                check_eq("abort_wr_data", 64'(wr_dat_q[i]), 64'(exp_final(i)));
            end
        end
        check_eq("abort_done_cnt", 64'(done_cnt), 64'd0);
        check_eq("abort_busy_next", 64'(busy_hist[11]), 64'd0);
        check_eq("abort_spike_vec", 64'(spike_vec), 64'(ev & N'(2'b11)));
`ifdef LIF_SCHED_SPIKE_COUNT_EN
        check_eq("abort_spike_count", 64'(spike_count), 64'($countones(ev & N'(2'b11))));
`endif

        // Recovery after abort
        load_random();
        run_ts(-1, -1);
        check_full_ts("post_abort");

        // Asynchronous reset during WRITE of neuron 1
        load_random();
        done_cnt = 0;
        @(negedge clk);
        t0 = edges;
        ts_start = 1'b1;
        @(negedge clk);
        ts_start = 1'b0;
        waited = 0;
        while ((edges - t0) < 9 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_eq("pre_reset_wr_en", 64'(bus.mem_wr_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_busy", 64'(ts_busy), 64'd0);
        check_eq("async_rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
        check_eq("async_rst_clear", 64'(bus.adder_clear), 64'd1);
        check_eq("async_rst_spike_vec", 64'(spike_vec), 64'd0);
        check_eq("async_rst_idx", 64'(bus.mem_idx), 64'd0);
        check_eq("async_rst_weight", 64'(bus.adder_weight), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check_eq("no_restart_done", 64'(done_cnt), 64'd0);
        check_eq("no_restart_busy", 64'(ts_busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
